// File: rtl/matrix_drain_collector.sv
// Collects elements streamed out of a systolic array's drain channels into full rows and
// writes each completed row to memory over a valid/ready port, one job per start_i pulse.
module matrix_drain_collector #(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned SYS_ARRAY_SIZE     = 4,
    parameter int unsigned DRAIN_CHANNEL_SIZE = (SYS_ARRAY_SIZE / 2) + (SYS_ARRAY_SIZE % 2),
    parameter int unsigned ADDR_WIDTH         = 64
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start_i,
    input  logic [ADDR_WIDTH-1:0]                        c_addr_i,
    input  logic [DRAIN_CHANNEL_SIZE*(DATA_WIDTH+1)-1:0] drain_data_i,
    output logic                                         mem_wr_valid_o,
    input  logic                                         mem_wr_ready_i,
    output logic [ADDR_WIDTH-1:0]                        mem_wr_addr_o,
    output logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0]         mem_wr_data_o,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         overflow_o
);
    localparam int unsigned N         = SYS_ARRAY_SIZE;
    localparam int unsigned C         = DRAIN_CHANNEL_SIZE;
    localparam int unsigned ROW_BITS  = N * DATA_WIDTH;
    localparam int unsigned ROW_BYTES = N * (DATA_WIDTH / 8);
    localparam int unsigned EW        = $clog2(N);
    localparam int unsigned RW        = $clog2(N + C) + 1;
    localparam int unsigned CW        = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned DONE_W    = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
    logic [CW-1:0]         r_rr_ptr, w_rr_nxt;
    logic                  r_lock, w_lock_nxt;
    logic [CW-1:0]         r_lock_ch, w_lock_ch_nxt;
    logic [DONE_W-1:0]     r_rows_wr, w_rows_wr_nxt;
    logic                  r_overflow, w_overflow_nxt;

    logic [ROW_BITS-1:0]   r_asm [C];
    logic [ROW_BITS-1:0]   w_asm_nxt [C];
    logic [EW-1:0]         r_elem_cnt [C];
    logic [EW-1:0]         w_elem_cnt_nxt [C];
    logic [RW-1:0]         r_row_num [C];
    logic [RW-1:0]         w_row_num_nxt [C];

    logic [ROW_BITS-1:0]   r_buf_data [C][2];
    logic [ROW_BITS-1:0]   w_buf_data_nxt [C][2];
    logic [RW-1:0]         r_buf_row [C][2];
    logic [RW-1:0]         w_buf_row_nxt [C][2];
    logic                  r_buf_wptr [C];
    logic                  w_buf_wptr_nxt [C];
    logic                  r_buf_rptr [C];
    logic                  w_buf_rptr_nxt [C];
    logic [1:0]            r_buf_cnt [C];
    logic [1:0]            w_buf_cnt_nxt [C];

    logic                  w_arb_any;
    logic [CW-1:0]         w_arb_ch;
    logic [CW-1:0]         w_grant_ch;
    logic                  w_valid;
    logic                  w_hs;
    logic [C-1:0]          w_pop;
    logic [C-1:0]          w_push;
    logic [ROW_BITS-1:0]   w_head_data;
    logic [RW-1:0]         w_head_row;
    logic [ADDR_WIDTH-1:0] w_head_addr;

    function automatic logic [CW-1:0] ch_wrap(input int unsigned v);
        return CW'(v % C);
    endfunction

    // Round-robin search starting at r_rr_ptr; the lowest offset from the pointer wins.
    always_comb begin
        w_arb_any = 1'b0;
        w_arb_ch  = r_rr_ptr;
        for (int i = C - 1; i >= 0; i--) begin
            if (r_buf_cnt[ch_wrap(32'(r_rr_ptr) + 32'(i))] != 2'd0) begin
                w_arb_any = 1'b1;
                w_arb_ch  = ch_wrap(32'(r_rr_ptr) + 32'(i));
            end
        end
    end

    // A stalled request stays locked to its channel so addr/data cannot change under it.
    assign w_grant_ch  = r_lock ? r_lock_ch : w_arb_ch;
    assign w_valid     = (r_state == StCollect) && (r_lock || w_arb_any);
    assign w_hs        = w_valid && mem_wr_ready_i;
    assign w_head_data = r_buf_data[w_grant_ch][r_buf_rptr[w_grant_ch]];
    assign w_head_row  = r_buf_row[w_grant_ch][r_buf_rptr[w_grant_ch]];
    assign w_head_addr = r_base + ADDR_WIDTH'(w_head_row) * ADDR_WIDTH'(ROW_BYTES);

    always_comb begin
        for (int k = 0; k < C; k++) begin
            w_pop[k] = w_hs && (w_grant_ch == CW'(k));
        end
    end

    assign mem_wr_valid_o = w_valid;
    assign mem_wr_addr_o  = w_valid ? w_head_addr : '0;
    assign mem_wr_data_o  = w_valid ? w_head_data : '0;
    assign busy_o         = (r_state != StIdle);
    assign done_o         = (r_state == StDone);
    assign overflow_o     = r_overflow;

    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_rr_nxt       = r_rr_ptr;
        w_lock_nxt     = r_lock;
        w_lock_ch_nxt  = r_lock_ch;
        w_rows_wr_nxt  = r_rows_wr;
        w_overflow_nxt = r_overflow;
        w_asm_nxt      = r_asm;
        w_elem_cnt_nxt = r_elem_cnt;
        w_row_num_nxt  = r_row_num;
        w_buf_data_nxt = r_buf_data;
        w_buf_row_nxt  = r_buf_row;
        w_buf_wptr_nxt = r_buf_wptr;
        w_buf_rptr_nxt = r_buf_rptr;
        w_buf_cnt_nxt  = r_buf_cnt;
        w_push         = '0;

        case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_nxt    = StCollect;
                    w_base_nxt     = c_addr_i;
                    w_overflow_nxt = 1'b0;
                    w_rr_nxt       = '0;
                    w_lock_nxt     = 1'b0;
                    w_lock_ch_nxt  = '0;
                    w_rows_wr_nxt  = '0;
                    for (int k = 0; k < C; k++) begin
                        w_asm_nxt[k]      = '0;
                        w_elem_cnt_nxt[k] = '0;
                        w_row_num_nxt[k]  = RW'(k);
                        w_buf_wptr_nxt[k] = 1'b0;
                        w_buf_rptr_nxt[k] = 1'b0;
                        w_buf_cnt_nxt[k]  = 2'd0;
                    end
                end
            end

            StCollect: begin
                if (w_hs) begin
                    w_rows_wr_nxt = r_rows_wr + 1'b1;
                    w_rr_nxt      = ch_wrap(32'(w_grant_ch) + 32'd1);
                    w_lock_nxt    = 1'b0;
                    if (r_rows_wr == DONE_W'(N - 1)) begin
                        w_state_nxt = StDone;
                    end
                end else if (w_valid) begin
                    w_lock_nxt    = 1'b1;
                    w_lock_ch_nxt = w_grant_ch;
                end

                for (int k = 0; k < C; k++) begin
                    w_buf_rptr_nxt[k] = r_buf_rptr[k] ^ w_pop[k];
                    if (drain_data_i[k*(DATA_WIDTH+1)]) begin
                        if (r_elem_cnt[k] == EW'(N - 1)) begin
                            if ((r_buf_cnt[k] == 2'd2) && !w_pop[k]) begin
                                w_overflow_nxt = 1'b1;
                            end else if (r_row_num[k] >= RW'(N)) begin
                                // Rows beyond this channel's share have no destination.
                                w_overflow_nxt    = 1'b1;
                                w_elem_cnt_nxt[k] = '0;
                            end else begin
                                w_push[k] = 1'b1;
                                w_buf_data_nxt[k][r_buf_wptr[k]] =
                                    {drain_data_i[k*(DATA_WIDTH+1)+1 +: DATA_WIDTH],
                                     r_asm[k][ROW_BITS-DATA_WIDTH-1:0]};
                                w_buf_row_nxt[k][r_buf_wptr[k]] = r_row_num[k];
                                w_buf_wptr_nxt[k] = ~r_buf_wptr[k];
                                w_row_num_nxt[k]  = r_row_num[k] + RW'(C);
                                w_elem_cnt_nxt[k] = '0;
                            end
                        end else begin
                            w_asm_nxt[k][32'(r_elem_cnt[k])*DATA_WIDTH +: DATA_WIDTH] =
                                drain_data_i[k*(DATA_WIDTH+1)+1 +: DATA_WIDTH];
                            w_elem_cnt_nxt[k] = r_elem_cnt[k] + 1'b1;
                        end
                    end
                    w_buf_cnt_nxt[k] = r_buf_cnt[k] + {1'b0, w_push[k]} - {1'b0, w_pop[k]};
                end
            end

            StDone: begin
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_base     <= '0;
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_ch  <= '0;
            r_rows_wr  <= '0;
            r_overflow <= 1'b0;
            for (int k = 0; k < C; k++) begin
                r_asm[k]      <= '0;
                r_elem_cnt[k] <= '0;
                r_row_num[k]  <= '0;
                r_buf_wptr[k] <= 1'b0;
                r_buf_rptr[k] <= 1'b0;
                r_buf_cnt[k]  <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    r_buf_data[k][e] <= '0;
                    r_buf_row[k][e]  <= '0;
                end
            end
        end else begin
            r_state    <= w_state_nxt;
            r_base     <= w_base_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock     <= w_lock_nxt;
            r_lock_ch  <= w_lock_ch_nxt;
            r_rows_wr  <= w_rows_wr_nxt;
            r_overflow <= w_overflow_nxt;
            r_asm      <= w_asm_nxt;
            r_elem_cnt <= w_elem_cnt_nxt;
            r_row_num  <= w_row_num_nxt;
            r_buf_data <= w_buf_data_nxt;
            r_buf_row  <= w_buf_row_nxt;
            r_buf_wptr <= w_buf_wptr_nxt;
            r_buf_rptr <= w_buf_rptr_nxt;
            r_buf_cnt  <= w_buf_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_drain_collector.sv
// Directed self-checking bench for matrix_drain_collector at N=4, C=2, DATA_WIDTH=8.
module tb_matrix_drain_collector;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int C  = 2;
    localparam int AW = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [AW-1:0]     c_addr_i;
    logic [C*(DW+1)-1:0] drain_data_i;
    logic              mem_wr_valid_o;
    logic              mem_wr_ready_i;
    logic [AW-1:0]     mem_wr_addr_o;
    logic [N*DW-1:0]   mem_wr_data_o;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    logic [AW-1:0] wr_addr [8];
    logic [31:0]   wr_data [8];
    logic [AW-1:0] exp_addr [4];
    logic [31:0]   exp_data [4];

    always #5 clk = ~clk;

    matrix_drain_collector #(
        .DATA_WIDTH         (DW),
        .SYS_ARRAY_SIZE     (N),
        .DRAIN_CHANNEL_SIZE (C),
        .ADDR_WIDTH         (AW)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .c_addr_i       (c_addr_i),
        .drain_data_i   (drain_data_i),
        .mem_wr_valid_o (mem_wr_valid_o),
        .mem_wr_ready_i (mem_wr_ready_i),
        .mem_wr_addr_o  (mem_wr_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
    );

    // Log every write that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (mem_wr_valid_o === 1'b1 && mem_wr_ready_i === 1'b1) begin
            if (wr_count < 8) begin
                wr_addr[wr_count] = mem_wr_addr_o;
                wr_data[wr_count] = mem_wr_data_o;
            end
            wr_count++;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_drain(input logic e0, input logic [7:0] d0, input logic e1,
                             input logic [7:0] d1);
        drain_data_i = {d1, e1, d0, e0};
    endtask

    task automatic start_job(input logic [AW-1:0] base);
        c_addr_i = base;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        c_addr_i = '0;
    endtask

    // ch0 carries rows 0 and 2, ch1 rows 1 and 3; row r holds bytes first+4r .. first+4r+3.
    task automatic stream_job(input logic [7:0] first, input int pulse_at,
                              input logic [AW-1:0] bad_base);
        logic [7:0] d0;
        logic [7:0] d1;
        for (int i = 0; i < 8; i++) begin
            d0 = first + 8'((i < 4) ? 0 : 8) + 8'(i % 4);
            d1 = d0 + 8'd4;
            if (i == pulse_at) begin
                start_i  = 1'b1;
                c_addr_i = bad_base;
            end
            set_drain(1'b1, d0, 1'b1, d1);
            tick();
            start_i  = 1'b0;
            c_addr_i = '0;
        end
        set_drain(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    function automatic logic [31:0] row_word(input logic [7:0] b0);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    task automatic expect_std(input logic [AW-1:0] base, input logic [7:0] first);
        for (int r = 0; r < 4; r++) begin
            exp_addr[r] = base + AW'(4 * r);
            exp_data[r] = row_word(first + 8'(4 * r));
        end
    endtask

    task automatic check_log(input string tag);
        check_eq($sformatf("%s_nwr", tag), 128'(wr_count), 128'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 128'(wr_addr[i]), 128'(exp_addr[i]));
            check_eq($sformatf("%s_data%0d", tag, i), 128'(wr_data[i]), 128'(exp_data[i]));
        end
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = 1'b1;
        end
        check_eq($sformatf("%s_done_seen", tag), 128'(seen), 128'd1);
        if (seen) begin
            check_eq($sformatf("%s_busy_in_done", tag), 128'(busy_o), 128'd1);
            check_eq($sformatf("%s_valid_in_done", tag), 128'(mem_wr_valid_o), 128'd0);
            @(negedge clk);
            check_eq($sformatf("%s_done_pulse", tag), 128'(done_o), 128'd0);
            check_eq($sformatf("%s_busy_after", tag), 128'(busy_o), 128'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq($sformatf("%s_valid", tag), 128'(mem_wr_valid_o), 128'd0);
        check_eq($sformatf("%s_busy", tag), 128'(busy_o), 128'd0);
        check_eq($sformatf("%s_done", tag), 128'(done_o), 128'd0);
        check_eq($sformatf("%s_ovf", tag), 128'(overflow_o), 128'd0);
        check_eq($sformatf("%s_addr", tag), 128'(mem_wr_addr_o), 128'd0);
        check_eq($sformatf("%s_data", tag), 128'(mem_wr_data_o), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] c0;
        logic [7:0] c1;
        logic       e0;
        logic       e1;

        rst_n          = 1'b0;
        start_i        = 1'b0;
        c_addr_i       = '0;
        mem_wr_ready_i = 1'b1;
        set_drain(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        tick();
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic job: both channels in lockstep, ready always high.
        tick();
        wr_count = 0;
        start_job(64'h1000);
        check_eq("t1_busy_start", 128'(busy_o), 128'd1);
        stream_job(8'h00, -1, '0);
        wait_done("t1");
        expect_std(64'h1000, 8'h00);
        check_log("t1");

        // Gapped streams with writes held off until all four rows are buffered.
        tick();
        mem_wr_ready_i = 1'b0;
        wr_count = 0;
        start_job(64'h0);
        c0 = 8'h40;
        c1 = 8'h50;
        for (int c = 0; c < 12; c++) begin
            e0 = (c % 3) != 2;
            e1 = (c % 3) != 0;
            set_drain(e0, c0, e1, c1);
            tick();
            if (e0) c0++;
            if (e1) c1++;
        end
        set_drain(1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        check_eq("t2_valid_held", 128'(mem_wr_valid_o), 128'd1);
        check_eq("t2_addr_held", 128'(mem_wr_addr_o), 128'h0);
        check_eq("t2_no_writes", 128'(wr_count), 128'd0);
        tick();
        mem_wr_ready_i = 1'b1;
        wait_done("t2");
        exp_addr[0] = 64'h0; exp_data[0] = 32'h43424140;
        exp_addr[1] = 64'h4; exp_data[1] = 32'h53525150;
        exp_addr[2] = 64'h8; exp_data[2] = 32'h47464544;
        exp_addr[3] = 64'hC; exp_data[3] = 32'h57565554;
        check_log("t2");

        // Backpressure: ch0 fills its buffer, third completed row overflows.
        tick();
        mem_wr_ready_i = 1'b0;
        wr_count = 0;
        start_job(64'h2000);
        for (int i = 0; i < 12; i++) begin
            set_drain(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00);
            tick();
            @(negedge clk);
            if (i >= 3) begin
                check_eq($sformatf("t3_valid_%0d", i), 128'(mem_wr_valid_o), 128'd1);
                check_eq($sformatf("t3_addr_%0d", i), 128'(mem_wr_addr_o), 128'h2000);
                check_eq($sformatf("t3_data_%0d", i), 128'(mem_wr_data_o), 128'h13121110);
            end
            if (i == 10) check_eq("t3_ovf_before", 128'(overflow_o), 128'd0);
            if (i == 11) check_eq("t3_ovf_after", 128'(overflow_o), 128'd1);
        end
        set_drain(1'b0, 8'h00, 1'b0, 8'h00);
        for (int j = 0; j < 12; j++) begin
            tick();
            @(negedge clk);
            check_eq($sformatf("t3_hold_addr_%0d", j), 128'(mem_wr_addr_o), 128'h2000);
            check_eq($sformatf("t3_hold_data_%0d", j), 128'(mem_wr_data_o), 128'h13121110);
            check_eq($sformatf("t3_hold_valid_%0d", j), 128'(mem_wr_valid_o), 128'd1);
        end
        tick();
        mem_wr_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_drain(1'b0, 8'h00, 1'b1, 8'h20 + 8'(i));
            tick();
        end
        set_drain(1'b0, 8'h00, 1'b0, 8'h00);
        wait_done("t3");
        check_eq("t3_ovf_sticky", 128'(overflow_o), 128'd1);
        exp_addr[0] = 64'h2000; exp_data[0] = 32'h13121110;
        exp_addr[1] = 64'h2008; exp_data[1] = 32'h17161514;
        exp_addr[2] = 64'h2004; exp_data[2] = 32'h23222120;
        exp_addr[3] = 64'h200C; exp_data[3] = 32'h27262524;
        check_log("t3");

        // Address wrap at the top of the address space; start also clears overflow.
        tick();
        wr_count = 0;
        start_job(64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("t4_ovf_cleared", 128'(overflow_o), 128'd0);
        stream_job(8'h30, -1, '0);
        wait_done("t4");
        check_eq("t4_row1_wrap", 128'(wr_addr[1]), 128'h0);
        expect_std(64'hFFFF_FFFF_FFFF_FFFC, 8'h30);
        check_log("t4");

        // Reset after two writes aborts the job; a fresh job then runs cleanly.
        tick();
        wr_count = 0;
        start_job(64'h3000);
        for (int i = 0; i < 4; i++) begin
            set_drain(1'b1, 8'h60 + 8'(i), 1'b1, 8'h64 + 8'(i));
            tick();
        end
        set_drain(1'b0, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 20 && wr_count < 2; k++) tick();
        check_eq("t5_two_writes", 128'(wr_count), 128'd2);
        check_eq("t5_busy_pre_rst", 128'(busy_o), 128'd1);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check_all_zero("t5_rst");
        rst_n = 1'b1;
        tick();
        wr_count = 0;
        for (int i = 0; i < 8; i++) begin
            set_drain(1'b1, 8'hEE, 1'b1, 8'hDD);
            tick();
        end
        set_drain(1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        check_eq("t5_no_write_after_rst", 128'(wr_count), 128'd0);
        check_eq("t5_idle_after_rst", 128'(busy_o), 128'd0);
        tick();
        start_job(64'h4000);
        stream_job(8'h70, -1, '0);
        wait_done("t5");
        expect_std(64'h4000, 8'h70);
        check_log("t5");

        // start_i pulsed mid-job with another base must be ignored.
        tick();
        wr_count = 0;
        start_job(64'h5000);
        stream_job(8'h80, 2, 64'h9000);
        wait_done("t6");
        expect_std(64'h5000, 8'h80);
        check_log("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
